vga_timing_gen: RTL and testbench

Parametrised VGA timing generator for the video path: clock-enable pixel divider, horizontal/vertical counters, programmable sync polarity, and configurable porch/sync widths. Provides the pixel coordinates, raw sync/blanking decode for the pixel generator, and a copy of those sync/blanking signals delayed by PIPE pixel ticks to align with a pipelined pixel generator. Frame and line strobes plus a frame counter drive game-state updates once per frame. Sits between the board clock and the pixel generator / RGB output register.

---
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, sync/blank decode,
// a PIPE-tick delayed copy of the decode, and line/frame strobes with a frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10,
  parameter int PIPE     = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic          p_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on_d,
  output logic          hsync_d,
  output logic          vsync_d,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ACT  = 1'(HS_POL);
  localparam logic          VS_ACT  = 1'(VS_POL);

  logic [DW-1:0] div_q;
  logic          line_end;
  logic          frame_end;
  logic [15:0]   frame_nxt;

  // The tick is gated by rst so no strobe escapes while the counters are being cleared.
  assign p_tick = ~rst & (div_q == DIV_MAX);

  always_comb begin
    line_end  = (pixel_x == H_MAX);
    frame_end = line_end && (pixel_y == V_MAX);
    frame_nxt = frame_cnt;
    if (p_tick && frame_end) frame_nxt = frame_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      pixel_x   <= '0;
      pixel_y   <= '0;
      frame_cnt <= '0;
    end else begin
      div_q     <= (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      frame_cnt <= frame_nxt;
      if (p_tick) begin
        if (line_end) begin
          pixel_x <= '0;
          pixel_y <= (pixel_y == V_MAX) ? '0 : pixel_y + 1'b1;
        end else begin
          pixel_x <= pixel_x + 1'b1;
        end
      end
    end
  end

  assign video_on    = (pixel_x < H_ACT) && (pixel_y < V_ACT);
  assign hsync       = ((pixel_x >= HS_BEG) && (pixel_x <= HS_END)) ? HS_ACT : ~HS_ACT;
  assign vsync       = ((pixel_y >= VS_BEG) && (pixel_y <= VS_END)) ? VS_ACT : ~VS_ACT;
  assign line_start  = p_tick & (pixel_x == '0);
  assign frame_start = line_start & (pixel_y == '0);

  generate
    if (PIPE == 0) begin : g_no_pipe
      assign video_on_d = video_on;
      assign hsync_d    = hsync;
      assign vsync_d    = vsync;
    end else begin : g_pipe
      logic [PIPE-1:0] von_sr;
      logic [PIPE-1:0] hs_sr;
      logic [PIPE-1:0] vs_sr;

      // Stage 0 captures the decode of the pixel being left on each tick edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          von_sr <= '0;
          hs_sr  <= {PIPE{~HS_ACT}};
          vs_sr  <= {PIPE{~VS_ACT}};
        end else if (p_tick) begin
          von_sr <= (von_sr << 1) | PIPE'(video_on);
          hs_sr  <= (hs_sr << 1)  | PIPE'(hsync);
          vs_sr  <= (vs_sr << 1)  | PIPE'(vsync);
        end
      end

      assign video_on_d = von_sr[PIPE-1];
      assign hsync_d    = hs_sr[PIPE-1];
      assign vsync_d    = vs_sr[PIPE-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two configurations checked every cycle against a
// tick-index model, plus pinned hand-computed values, random resets and a frame-count wrap.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, cd, hp, vp, pipe;
  } cfg_t;

  typedef struct packed {
    logic        tick;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        von, hs, vs, vond, hsd, vsd, ls, fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct packed { int n; int sel; int exp; } pin_t;

  localparam int OBS_W = $bits(obs_t);
  localparam cfg_t CA = '{ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1, cd:1, hp:1, vp:1, pipe:2};
  localparam cfg_t CB = '{ha:6, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:1, cd:3, hp:0, vp:0, pipe:1};

  localparam int S_TICK_A = 0, S_X_A = 1, S_Y_A = 2, S_VON_A = 3, S_HS_A = 4, S_VS_A = 5;
  localparam int S_VOND_A = 6, S_LS_A = 7, S_FS_A = 8, S_FC_A = 9, S_TICK_B = 10;
  localparam int S_FS_B = 11, S_HS_B = 12, S_VS_B = 13, S_FC_B = 14;

  // n = -1 means "while rst is held after the first reset edge".
  localparam int NP = 30;
  localparam pin_t PINS [NP] = '{
    '{-1, S_TICK_A, 0}, '{-1, S_VON_A, 1}, '{-1, S_HS_A, 0}, '{-1, S_VS_B, 1}, '{-1, S_FS_A, 0},
    '{0, S_FS_A, 1}, '{0, S_X_A, 0}, '{0, S_VOND_A, 0}, '{1, S_VOND_A, 0}, '{2, S_VOND_A, 1},
    '{3, S_VON_A, 1}, '{4, S_VON_A, 0}, '{4, S_HS_A, 0}, '{5, S_HS_A, 1}, '{6, S_HS_A, 1},
    '{7, S_HS_A, 0}, '{8, S_LS_A, 1}, '{8, S_Y_A, 1}, '{32, S_VS_A, 1}, '{40, S_VS_A, 0},
    '{143, S_FC_A, 2}, '{144, S_FC_A, 3}, '{1, S_TICK_B, 0}, '{2, S_FS_B, 1}, '{5, S_TICK_B, 1},
    '{23, S_HS_B, 1}, '{24, S_HS_B, 0}, '{33, S_HS_B, 1}, '{311, S_FC_B, 0}, '{312, S_FC_B, 1}
  };

  logic clk = 1'b0;
  logic rst;
  logic       p_tick_a, video_on_a, hsync_a, vsync_a, video_on_d_a, hsync_d_a, vsync_d_a;
  logic       line_start_a, frame_start_a;
  logic [3:0] pixel_x_a, pixel_y_a;
  logic [15:0] frame_cnt_a;
  logic       p_tick_b, video_on_b, hsync_b, vsync_b, video_on_d_b, hsync_d_b, vsync_d_b;
  logic       line_start_b, frame_start_b;
  logic [4:0] pixel_x_b, pixel_y_b;
  logic [15:0] frame_cnt_b;

  int total = 0;
  int bad = 0;
  int n = 0;
  logic started = 1'b0;
  int fbase_a, fbase_b, wrap_n;
  logic pin_en;
  logic [OBS_W-1:0] exp_q[$];

  vga_timing_gen #(
    .H_ACTIVE(CA.ha), .H_FP(CA.hf), .H_SYNC(CA.hs), .H_BP(CA.hb),
    .V_ACTIVE(CA.va), .V_FP(CA.vf), .V_SYNC(CA.vs), .V_BP(CA.vb),
    .CLK_DIV(CA.cd), .HS_POL(CA.hp), .VS_POL(CA.vp), .CW(4), .PIPE(CA.pipe)
  ) dut_a (
    .clk(clk), .rst(rst), .p_tick(p_tick_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
    .video_on(video_on_a), .hsync(hsync_a), .vsync(vsync_a), .video_on_d(video_on_d_a),
    .hsync_d(hsync_d_a), .vsync_d(vsync_d_a), .line_start(line_start_a),
    .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hs), .H_BP(CB.hb),
    .V_ACTIVE(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb),
    .CLK_DIV(CB.cd), .HS_POL(CB.hp), .VS_POL(CB.vp), .CW(5), .PIPE(CB.pipe)
  ) dut_b (
    .clk(clk), .rst(rst), .p_tick(p_tick_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
    .video_on(video_on_b), .hsync(hsync_b), .vsync(vsync_b), .video_on_d(video_on_d_b),
    .hsync_d(hsync_d_b), .vsync_d(vsync_d_b), .line_start(line_start_b),
    .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // n counts clk edges since the last reset edge.
  always @(posedge clk) begin
    if (rst) begin
      n       <= 0;
      started <= 1'b1;
    end else begin
      n <= n + 1;
    end
  end

  // ---------------- model ----------------
  function automatic logic [2:0] decode(cfg_t c, int l);
    int ht, vt, x, y, hs0, vs0;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    x   = l % ht;
    y   = (l / ht) % vt;
    hs0 = c.ha + c.hf;
    vs0 = c.va + c.vf;
    return {(x < c.ha) && (y < c.va),
            ((x >= hs0) && (x < hs0 + c.hs)) ? c.hp[0] : ~c.hp[0],
            ((y >= vs0) && (y < vs0 + c.vs)) ? c.vp[0] : ~c.vp[0]};
  endfunction

  function automatic obs_t model(cfg_t c, int cyc, logic r, int fbase);
    obs_t o;
    int ht, vt, l;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    l  = cyc / c.cd;
    o.tick = !r && ((cyc % c.cd) == c.cd - 1);
    o.x    = 8'(l % ht);
    o.y    = 8'((l / ht) % vt);
    {o.von, o.hs, o.vs} = decode(c, l);
    if (l < c.pipe) {o.vond, o.hsd, o.vsd} = {1'b0, ~c.hp[0], ~c.vp[0]};
    else            {o.vond, o.hsd, o.vsd} = decode(c, l - c.pipe);
    o.ls = o.tick && (o.x == 8'd0);
    o.fs = o.ls && (o.y == 8'd0);
    o.fc = 16'((fbase + l / (ht * vt)) & 32'hFFFF);
    return o;
  endfunction

  function automatic obs_t act_a();
    return {p_tick_a, 8'(pixel_x_a), 8'(pixel_y_a), video_on_a, hsync_a, vsync_a,
            video_on_d_a, hsync_d_a, vsync_d_a, line_start_a, frame_start_a, frame_cnt_a};
  endfunction

  function automatic obs_t act_b();
    return {p_tick_b, 8'(pixel_x_b), 8'(pixel_y_b), video_on_b, hsync_b, vsync_b,
            video_on_d_b, hsync_d_b, vsync_d_b, line_start_b, frame_start_b, frame_cnt_b};
  endfunction

  function automatic logic [15:0] pick(int sel);
    case (sel)
      S_TICK_A: return 16'(p_tick_a);
      S_X_A:    return 16'(pixel_x_a);
      S_Y_A:    return 16'(pixel_y_a);
      S_VON_A:  return 16'(video_on_a);
      S_HS_A:   return 16'(hsync_a);
      S_VS_A:   return 16'(vsync_a);
      S_VOND_A: return 16'(video_on_d_a);
      S_LS_A:   return 16'(line_start_a);
      S_FS_A:   return 16'(frame_start_a);
      S_FC_A:   return frame_cnt_a;
      S_TICK_B: return 16'(p_tick_b);
      S_FS_B:   return 16'(frame_start_b);
      S_HS_B:   return 16'(hsync_b);
      S_VS_B:   return 16'(vsync_b);
      default:  return frame_cnt_b;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s n=%0d rst=%0b: got %0h want %0h", nm, n, rst, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      exp_q.push_back(model(CA, n, rst, fbase_a));
      exp_q.push_back(model(CB, n, rst, fbase_b));
      chk("cycle_a", 64'(act_a()), 64'(exp_q.pop_front()));
      chk("cycle_b", 64'(act_b()), 64'(exp_q.pop_front()));
      if (pin_en) begin
        for (int i = 0; i < NP; i++) begin
          if ((PINS[i].n < 0) ? rst : (!rst && n == PINS[i].n))
            chk($sformatf("pin%0d_sel%0d", i, PINS[i].sel), 64'(pick(PINS[i].sel)),
                64'(PINS[i].exp));
        end
      end
      if (wrap_n > 0 && !rst && n == wrap_n - 1) chk("wrap_pre", 64'(frame_cnt_a), 64'hFFFF);
      if (wrap_n > 0 && !rst && n == wrap_n)     chk("wrap_zero", 64'(frame_cnt_a), 64'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(int k);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        fbase_a = 0;
        fbase_b = 0;
      end
    end
    rst = 1'b0;
  endtask

  task automatic run(int k);
    repeat (k) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    fbase_a = 0;
    fbase_b = 0;
    wrap_n  = -1;
    pin_en  = 1'b1;
    run(3);
    #1 rst = 1'b0;
    run(330);
    pin_en = 1'b0;

    // one-cycle reset in the middle of a frame, then random run lengths and resets
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      run($urandom_range(30, 500));
      do_reset($urandom_range(1, 3));
    end

    // frame counter wrap: preload 0xFFFF completed frames at a frame start of A
    run(100);
    @(negedge clk);
    for (int i = 0; i < 48 && (n % 48) != 0; i++) @(negedge clk);
    #2;
    force dut_a.frame_cnt = 16'hFFFF;
    fbase_a = 32'hFFFF - (n / 48);
    wrap_n  = n + 48;
    @(negedge clk);
    #2 release dut_a.frame_cnt;
    run(120);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
